key_schedule_ctrl: RTL and testbench

Sequences the existing single-round key-expansion module GENERATE_KEY to expand a 128-bit cipher key into all 11 AES-128 round keys. The expansion is iterative: one round per clock, with the generator's output fed back as its next input. Results go into an 11-entry round-key register file. The file is read by index from the encrypt/decrypt round datapath. One expansion runs at a time; a start request is honoured only when idle.

---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/generate_key.sv | 36 +++
 rtl/key_schedule_ctrl.sv | 101 ++++++++++
 tb/tb_key_schedule_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, controller state type and GF(2^8) helpers
//
// Purpose: constants, FSM state enum and byte-level helpers (S-box, round
// constant) shared by the key-schedule controller and the round-key generator.
// Ports: none (package).

package aes_pkg;

  localparam int AES_NR   = 10;
  localparam int AES_KW   = 128;
  localparam int RK_IDX_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed rather than tabulated: inverse as x^254 (square-and-multiply
  // chain x^2 * x^4 * ... * x^128), which maps 0 to 0 as required, then the
  // affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Round constant for expansion step 0..9 (producing round key 1..10).
  function automatic logic [7:0] rcon(input logic [RK_IDX_W-1:0] rnd);
    logic [7:0] c;
    case (rnd)
      4'd0:    c = 8'h01;
      4'd1:    c = 8'h02;
      4'd2:    c = 8'h04;
      4'd3:    c = 8'h08;
      4'd4:    c = 8'h10;
      4'd5:    c = 8'h20;
      4'd6:    c = 8'h40;
      4'd7:    c = 8'h80;
      4'd8:    c = 8'h1b;
      4'd9:    c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/generate_key.sv
// rtl/generate_key.sv - single-round AES-128 key expansion (combinational)
//
// Purpose: derives round key i+1 from round key i.
// Ports:
//   key_in  [AES_KW]   round key i
//   round   [RK_IDX_W] expansion step i (0..9), selects the round constant
//   key_out [AES_KW]   round key i+1

module generate_key
  import aes_pkg::*;
(
  input  logic [AES_KW-1:0]   key_in,
  input  logic [RK_IDX_W-1:0] round,
  output logic [AES_KW-1:0]   key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, temp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    w0   = key_in[127:96];
    w1   = key_in[95:64];
    w2   = key_in[63:32];
    w3   = key_in[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]) ^ rcon(round), sbox(rot[23:16]),
            sbox(rot[15:8]), sbox(rot[7:0])};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    key_out = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - iterative AES-128 key schedule into an 11-entry round-key file
//
// Purpose: on an accepted start, expands key_in one round per clock through
// generate_key and stores round keys 0..NR for the round datapath to read.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, key_in     expansion request and cipher key (sampled only in IDLE)
//   busy              expansion in progress
//   done              one-cycle pulse after round key NR is written
//   keys_valid        file holds the complete schedule of the last accepted key
//   rd_idx, rd_key    combinational read port; zero for rd_idx > NR

module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = AES_KW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KW-1:0]       key_in,
  output logic                busy,
  output logic                done,
  output logic                keys_valid,
  input  logic [RK_IDX_W-1:0] rd_idx,
  output logic [KW-1:0]       rd_key
);

  state_t                state_q, state_d;
  logic [RK_IDX_W-1:0]   rnd_q, rnd_d;
  logic                  done_q, done_d;
  logic                  keys_valid_q, keys_valid_d;
  logic [KW-1:0]         rk_q [0:NR];
  logic [KW-1:0]         rk_d [0:NR];

  logic [RK_IDX_W-1:0]   wr_idx;
  logic [RK_IDX_W-1:0]   gen_round;
  logic [KW-1:0]         gen_out;

  // rnd rests at NR once a schedule completes; keep the generator's round
  // input inside 0..NR-1 outside EXPAND.
  assign gen_round = (state_q == EXPAND) ? rnd_q : '0;
  assign wr_idx    = rnd_q + RK_IDX_W'(1);

  generate_key u_generate_key (
    .key_in  (rk_q[rnd_q]),
    .round   (gen_round),
    .key_out (gen_out)
  );

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    done_d       = 1'b0;
    keys_valid_d = keys_valid_q;
    rk_d         = rk_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rk_d[0]      = key_in;
          rnd_d        = '0;
          keys_valid_d = 1'b0;
          state_d      = EXPAND;
        end
      end
      EXPAND: begin
        rk_d[wr_idx] = gen_out;
        rnd_d        = wr_idx;
        if (rnd_q == RK_IDX_W'(NR - 1)) begin
          done_d       = 1'b1;
          keys_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rnd_q        <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
      rk_q         <= rk_d;
    end
  end

  assign busy       = (state_q == EXPAND);
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rd_key     = (rd_idx <= RK_IDX_W'(NR)) ? rk_q[rd_idx] : '0;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - scoreboard bench for key_schedule_ctrl

module tb_key_schedule_ctrl;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [127:0] k0;
    logic [127:0] k1;
    logic [127:0] k10;
  } sb_entry_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  sb_entry_t sb_q[$];
  int        tests_run;
  int        tests_failed;
  int        nbusy, ncyc, nkv, ndone;

  key_schedule_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input int idx, input logic [127:0] exp);
    rd_idx = 4'(idx);
    #1;
    check(tag, rd_key, exp);
  endtask

  task automatic push_key(input logic [127:0] k0, input logic [127:0] k1,
                          input logic [127:0] k10);
    sb_entry_t e;
    e.k0  = k0;
    e.k1  = k1;
    e.k10 = k10;
    sb_q.push_back(e);
  endtask

  // Called just after the accepting edge (or later). Returns busy cycles seen,
  // negedges until done, and busy cycles that also showed keys_valid; on done
  // pops the scoreboard and compares the file contents.
  task automatic wait_done(output int nb, output int nc, output int nk);
    sb_entry_t e;
    nb = 0;
    nc = 0;
    nk = 0;
    while (nc < 40) begin
      @(negedge clk);
      nc++;
      if (done) break;
      if (busy) nb++;
      if (busy && keys_valid) nk++;
    end
    check("done_seen", 128'(done), 128'd1);
    if (done) begin
      check("kv_at_done", 128'(keys_valid), 128'd1);
      check("busy_at_done", 128'(busy), 128'd0);
      if (sb_q.size() == 0) begin
        check("sb_nonempty", 128'd0, 128'd1);
      end else begin
        e = sb_q.pop_front();
        read_check("entry0", 0, e.k0);
        read_check("entry1", 1, e.k1);
        read_check("entry10", 10, e.k10);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = '0;
    rd_idx = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_kv", 128'(keys_valid), 128'd0);
    read_check("rst_entry0", 0, '0);
    read_check("rst_entry10", 10, '0);

    // FIPS-197 A.1 expansion with latency/handshake
    start = 1'b1; key_in = K1;
    push_key(K1, K1_R1, K1_R10);
    @(posedge clk); #1 start = 1'b0; key_in = '0;
    wait_done(nbusy, ncyc, nkv);
    check("a1_busy_cycles", 128'(nbusy), 128'd10);
    check("a1_latency", 128'(ncyc - 1), 128'd10);
    check("a1_kv_during", 128'(nkv), 128'd0);
    for (int i = 11; i < 16; i++) read_check($sformatf("oob_%0d", i), i, '0);
    @(negedge clk);
    check("done_pulse", 128'(done), 128'd0);
    check("kv_hold", 128'(keys_valid), 128'd1);

    // start while busy is ignored
    start = 1'b1; key_in = K1;
    push_key(K1, K1_R1, K1_R10);
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; key_in = K2;
    @(posedge clk); #1 start = 1'b0; key_in = '0;
    wait_done(nbusy, ncyc, nkv);
    check("ign_busy_cycles", 128'(nbusy), 128'd5);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("ign_single_done", 128'(ndone), 128'd0);

    // back-to-back with start held across done
    start = 1'b1; key_in = K1;
    push_key(K1, K1_R1, K1_R10);
    push_key(K2, K2_R1, K2_R10);
    @(posedge clk);
    wait_done(nbusy, ncyc, nkv);
    check("b2b_first_busy", 128'(nbusy), 128'd10);
    key_in = K2;
    @(posedge clk); #1 start = 1'b0; key_in = '0;
    check("b2b_restart_busy", 128'(busy), 128'd1);
    check("b2b_restart_kv", 128'(keys_valid), 128'd0);
    wait_done(nbusy, ncyc, nkv);
    check("b2b_second_busy", 128'(nbusy), 128'd10);
    check("b2b_second_lat", 128'(ncyc), 128'd11);
    check("b2b_kv_during", 128'(nkv), 128'd0);

    // reset at rnd=6 aborts and clears
    @(negedge clk);
    start = 1'b1; key_in = K1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_done", 128'(done), 128'd0);
    check("mid_rst_kv", 128'(keys_valid), 128'd0);
    for (int i = 0; i <= 10; i++) read_check($sformatf("mid_rst_entry%0d", i), i, '0);
    @(negedge clk);
    start = 1'b1; key_in = K2;
    push_key(K2, K2_R1, K2_R10);
    @(posedge clk); #1 start = 1'b0; key_in = '0;
    wait_done(nbusy, ncyc, nkv);
    check("post_rst_busy", 128'(nbusy), 128'd10);

    // reset and start on the same edge: reset wins
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; key_in = K1;
    @(posedge clk); #1 rst_n = 1'b1; start = 1'b0; key_in = '0;
    check("rs_busy", 128'(busy), 128'd0);
    check("rs_kv", 128'(keys_valid), 128'd0);
    read_check("rs_entry0", 0, '0);
    @(negedge clk);
    check("rs_still_idle", 128'(busy), 128'd0);
    check("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
